// File: rtl/queue_fifo.sv
// queue_fifo: synchronous circular-buffer FIFO with a registered pop output
// and an explicit occupancy counter.
// Optional status outputs (full_out, empty_out, sticky overflow_out) are
// compiled in when the macro QUEUE_STATUS_EN is defined.
// DEPTH must be a power of two so that the pointers wrap naturally.
// LEN_W must be wide enough to hold DEPTH itself.
module queue_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_10khz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic [LEN_W-1:0]  len_out,
`ifdef QUEUE_STATUS_EN
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out,
`endif
  output logic [DATA_W-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

  // Storage: no reset, so it maps onto RAM; contents only become visible
  // through a pop, which requires len > 0, so unwritten slots never escape.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LEN_W-1:0]  len_q,  len_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic is_full;
  logic is_empty;
  logic pop_ok;
  logic push_ok;

  assign is_full  = (len_q == LEN_FULL);
  assign is_empty = (len_q == '0);

  // Accept decisions: a pop needs data present; a push needs a free slot,
  // or the slot being vacated by a pop on the same edge.
  always_comb begin
    pop_ok  = dequeue_in && !is_empty;
    push_ok = enqueue_in && (!is_full || pop_ok);
  end

  // Next-state for pointers, occupancy and the output word.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    len_d  = len_q;
    dout_d = dout_q;

    if (push_ok) begin
      wptr_d = wptr_q + PTR_W'(1);
    end

    if (pop_ok) begin
      rptr_d = rptr_q + PTR_W'(1);
      dout_d = mem_q[rptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   len_d = len_q + LEN_W'(1);
      2'b01:   len_d = len_q - LEN_W'(1);
      default: len_d = len_q;
    endcase
  end

  // Write port: the push slot is wptr, which equals the slot being read out
  // when a push and pop coincide on a full queue (read sees the old word).
  always_ff @(posedge clk_10khz) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  // Control and output registers; reset empties the queue immediately.
  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      len_q  <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      len_q  <= len_d;
      dout_q <= dout_d;
    end
  end

  assign len_out  = len_q;
  assign data_out = dout_q;

`ifdef QUEUE_STATUS_EN
  logic overflow_q, overflow_d;

  // Sticky overflow: any enqueue that was refused (full, no concurrent pop).
  always_comb begin
    overflow_d = overflow_q;
    if (enqueue_in && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow flag register, cleared only by reset.
  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign full_out     = is_full;
  assign empty_out    = is_empty;
  assign overflow_out = overflow_q;
`endif

endmodule

// File: tb/tb_queue_fifo.sv
// Testbench for queue_fifo: table of directed vectors plus hand-written
// sequences for asynchronous reset and post-reset behaviour.
`timescale 1us/1ns
module tb_queue_fifo;

  logic       clk_10khz;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic [3:0] len_out;
  logic [7:0] data_out;
`ifdef QUEUE_STATUS_EN
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;
`endif

  int errors = 0;
  int checks = 0;

  queue_fifo #(.DATA_W(8), .DEPTH(8), .LEN_W(4)) dut (
    .clk_10khz   (clk_10khz),
    .reset       (reset),
    .data_in     (data_in),
    .enqueue_in  (enqueue_in),
    .dequeue_in  (dequeue_in),
    .len_out     (len_out),
`ifdef QUEUE_STATUS_EN
    .full_out    (full_out),
    .empty_out   (empty_out),
    .overflow_out(overflow_out),
`endif
    .data_out    (data_out)
  );

  initial clk_10khz = 1'b0;
  always #50 clk_10khz = ~clk_10khz;

  typedef struct {
    logic       enq;
    logic       deq;
    logic [7:0] din;
    logic [3:0] exp_len;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic f, input logic e, input logic o);
`ifdef QUEUE_STATUS_EN
    chk({tag, " full"}, int'(full_out), int'(f));
    chk({tag, " empty"}, int'(empty_out), int'(e));
    chk({tag, " ovf"}, int'(overflow_out), int'(o));
`endif
  endtask

  task automatic step(input logic enq, input logic deq, input logic [7:0] din);
    enqueue_in = enq;
    dequeue_in = deq;
    data_in    = din;
    @(posedge clk_10khz);
    #1;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
  endtask

  // Watchdog: the run is short and fully deterministic.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // enq deq din  len dout  full empty ovf
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h01, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h02, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h03, 4'd4, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h04, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h05, 4'd6, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h06, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h07, 4'd8, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h08, 4'd8, 8'h00, 1'b1, 1'b0, 1'b1}; // dropped
    vecs[9]  = '{1'b1, 1'b0, 8'hFF, 4'd8, 8'h00, 1'b1, 1'b0, 1'b1}; // dropped
    vecs[10] = '{1'b0, 1'b1, 8'h00, 4'd7, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 8'h77, 4'd7, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 4'd6, 8'h02, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 4'd5, 8'h03, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 4'd4, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 4'd3, 8'h05, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 4'd2, 8'h06, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 4'd1, 8'h07, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h77, 1'b0, 1'b1, 1'b1}; // wrapped slot 0
    vecs[19] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h77, 1'b0, 1'b1, 1'b1}; // pop while empty
    vecs[20] = '{1'b1, 1'b1, 8'h55, 4'd1, 8'h77, 1'b0, 1'b0, 1'b1}; // no pass-through

    reset      = 1'b0;
    data_in    = 8'h00;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    repeat (2) @(posedge clk_10khz);
    #1;
    chk("reset len", int'(len_out), 0);
    chk("reset dout", int'(data_out), 0);
    chk_status("reset", 1'b0, 1'b1, 1'b0);
    @(negedge clk_10khz);
    reset = 1'b1;
    @(posedge clk_10khz);
    #1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].enq, vecs[i].deq, vecs[i].din);
      $display("vec %0d enq=%0b deq=%0b din=%02h -> len=%0d dout=%02h (exp len=%0d dout=%02h)",
               i, vecs[i].enq, vecs[i].deq, vecs[i].din, len_out, data_out,
               vecs[i].exp_len, vecs[i].exp_dout);
      chk($sformatf("vec%0d len", i), int'(len_out), int'(vecs[i].exp_len));
      chk($sformatf("vec%0d dout", i), int'(data_out), int'(vecs[i].exp_dout));
      chk_status($sformatf("vec%0d", i), vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_ovf);
    end

    // Asynchronous reset mid-stream (len=1): must clear before any edge.
    @(negedge clk_10khz);
    #10;
    reset = 1'b0;
    #1;
    $display("async reset -> len=%0d dout=%02h", len_out, data_out);
    chk("async reset len", int'(len_out), 0);
    chk("async reset dout", int'(data_out), 0);
    chk_status("async reset", 1'b0, 1'b1, 1'b0);
    @(negedge clk_10khz);
    reset = 1'b1;
    @(posedge clk_10khz);
    #1;
    chk("post reset len", int'(len_out), 0);

    // Pop after reset: the word pushed before reset must be gone.
    step(1'b0, 1'b1, 8'h00);
    $display("pop after reset -> len=%0d dout=%02h", len_out, data_out);
    chk("pop after reset len", int'(len_out), 0);
    chk("pop after reset dout", int'(data_out), 0);

    // Push then pop returns the new word with one-cycle latency.
    step(1'b1, 1'b0, 8'h3C);
    $display("push 3C -> len=%0d dout=%02h", len_out, data_out);
    chk("push 3C len", int'(len_out), 1);
    chk("push 3C dout", int'(data_out), 0);
    step(1'b0, 1'b1, 8'h00);
    $display("pop -> len=%0d dout=%02h", len_out, data_out);
    chk("pop 3C len", int'(len_out), 0);
    chk("pop 3C dout", int'(data_out), 8'h3C);

    // Fill to full again, then push+pop at full: old head out, len stays 8.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 8'hC0 + 8'(k));
    end
    chk("refill len", int'(len_out), 8);
    step(1'b1, 1'b1, 8'hEE);
    $display("push EE + pop at full -> len=%0d dout=%02h", len_out, data_out);
    chk("full push+pop len", int'(len_out), 8);
    chk("full push+pop dout", int'(data_out), 8'hC0);
    chk_status("full push+pop", 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d dout", k), int'(data_out), int'(8'hC0 + 8'(k)));
    end
    step(1'b0, 1'b1, 8'h00);
    $display("drain last -> len=%0d dout=%02h", len_out, data_out);
    chk("drain last dout", int'(data_out), 8'hEE);
    chk("drain last len", int'(len_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
